// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and cache line layout for cache_ctrl.
// Geometry: WAYS-way set associative, TOTAL_SIZE one-word lines,
// RAM_DEPTH-word backing store, WIDTH-bit words.
package cache_pkg;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned TOTAL_SIZE = 16;
  localparam int unsigned RAM_DEPTH  = 256;
  localparam int unsigned WIDTH      = 8;

  localparam int unsigned SETS   = TOTAL_SIZE / WAYS;
  localparam int unsigned AW     = $clog2(RAM_DEPTH);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = AW - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned STAT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } ctrl_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } line_t;

endpackage

// File: rtl/lru_tracker.sv
// Per-set LRU age tracking. Age 0 = most recent, WAYS-1 = least recent.
// Ports:
//   clk, rst              clock, synchronous active-high reset (ages = way index)
//   rd_set / victim_c     set to query / way holding age WAYS-1 (combinational)
//   upd_en/upd_set/upd_way  mark way as most recently used
module lru_tracker
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_set,
  output logic [WAY_W-1:0] victim_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way
);

  logic [WAY_W-1:0] age [SETS][WAYS];

  // Ages stay a permutation: younger-than-accessed ways age by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++)
        for (int w = 0; w < int'(WAYS); w++)
          age[s][w] <= WAY_W'(w);
    end else if (upd_en) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (WAY_W'(w) == upd_way)
          age[upd_set][w] <= '0;
        else if (age[upd_set][w] < age[upd_set][upd_way])
          age[upd_set][w] <= age[upd_set][w] + WAY_W'(1);
      end
    end
  end

  // Oldest way of the queried set.
  always_comb begin
    victim_c = '0;
    for (int w = 0; w < int'(WAYS); w++)
      if (age[rd_set][w] == WAY_W'(WAYS - 1))
        victim_c = WAY_W'(w);
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, read-allocate set-associative cache sequencer.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata   CPU request
//   resp_valid/resp_rdata/resp_hit  one-cycle response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  backing RAM
// Optional: CACHE_CTRL_STATS_EN adds saturating hit_count/miss_count.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
`endif
);

  ctrl_state_t state, state_next;

  logic             we_q, hit_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WAY_W-1:0] way_q, way_d;
  line_t            lines [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[AW-1:IDX_W];

  logic             hit_c, inv_found_c;
  logic [WAY_W-1:0] hit_way_c, inv_way_c, victim_c;
  logic             latch_req, latch_lookup, line_wr, lru_upd;
  logic [WAY_W-1:0] lru_way;
  logic [WIDTH-1:0] line_data, resp_rdata_d;
  logic             resp_hit_d;

  lru_tracker u_lru (
    .clk      (clk),
    .rst      (rst),
    .rd_set   (idx),
    .victim_c (victim_c),
    .upd_en   (lru_upd),
    .upd_set  (idx),
    .upd_way  (lru_way)
  );

  // Tag match and lowest-index invalid way for the latched set.
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    inv_found_c = 1'b0;
    inv_way_c   = '0;
    for (int w = 0; w < int'(WAYS); w++)
      if (lines[idx][w].valid && lines[idx][w].tag == tag) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    for (int w = int'(WAYS) - 1; w >= 0; w--)
      if (!lines[idx][w].valid) begin
        inv_found_c = 1'b1;
        inv_way_c   = WAY_W'(w);
      end
  end

  // Next state, array/LRU controls and next registered outputs.
  always_comb begin
    state_next   = state;
    latch_req    = 1'b0;
    latch_lookup = 1'b0;
    line_wr      = 1'b0;
    line_data    = mem_rdata;
    lru_upd      = 1'b0;
    lru_way      = way_q;
    resp_rdata_d = '0;
    resp_hit_d   = 1'b0;
    way_d        = hit_c ? hit_way_c : (inv_found_c ? inv_way_c : victim_c);
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          latch_req  = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        latch_lookup = 1'b1;
        if (we_q) begin
          state_next = MEM_WR;
        end else if (hit_c) begin
          lru_upd      = 1'b1;
          lru_way      = hit_way_c;
          resp_rdata_d = lines[idx][hit_way_c].data;
          resp_hit_d   = 1'b1;
          state_next   = RESP;
        end else begin
          state_next = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          line_wr      = 1'b1;
          lru_upd      = 1'b1;
          resp_rdata_d = mem_rdata;
          state_next   = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          line_wr    = hit_q;
          line_data  = wdata_q;
          lru_upd    = hit_q;
          resp_hit_d = hit_q;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      way_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_next;
      if (latch_req) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (latch_lookup) begin
        hit_q <= hit_c;
        way_q <= way_d;
      end
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      resp_rdata <= (state_next == RESP) ? resp_rdata_d : '0;
      resp_hit   <= (state_next == RESP) ? resp_hit_d : 1'b0;
      mem_req    <= (state_next == MEM_RD) || (state_next == MEM_WR);
      mem_we     <= (state_next == MEM_WR);
      mem_addr   <= ((state_next == MEM_RD) || (state_next == MEM_WR)) ? addr_q : '0;
      mem_wdata  <= (state_next == MEM_WR) ? wdata_q : '0;
    end
  end

  // Line storage: only valid bits are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++)
        for (int w = 0; w < int'(WAYS); w++)
          lines[s][w].valid <= 1'b0;
    end else if (line_wr) begin
      lines[idx][way_q] <= '{valid: 1'b1, tag: tag, data: line_data};
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  // Saturating hit/miss counters, sampled as LOOKUP exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit_c && hit_count != '1)
        hit_count <= hit_count + STAT_W'(1);
      else if (!hit_c && miss_count != '1)
        miss_count <= miss_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a delayed-ack RAM model.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_hit;
  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack = 1'b0;
  logic [WIDTH-1:0] mem_rdata = '0;
`ifdef CACHE_CTRL_STATS_EN
  logic [STAT_W-1:0] hit_count, miss_count;
`endif

  cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] rdata;
    logic             hit;
  } resp_t;

  typedef struct {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } memx_t;

  resp_t            exp_resp [$];
  memx_t            exp_mem  [$];
  int               checks    = 0;
  int               passed    = 0;
  int               ram_delay = 3;
  logic [WIDTH-1:0] ram [RAM_DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_resp.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got resp_valid=1 required no response");
        end else begin
          e = exp_resp.pop_front();
          chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
          chk("resp_hit", 32'(resp_hit), 32'(e.hit));
        end
      end
    end
  end

  // RAM model: ack after ram_delay cycles of mem_req; checks each access.
  initial begin
    int    cnt = 0;
    memx_t m;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt     = 0;
        chk("mem_req_drop_after_ack", 32'(mem_req), 32'd0);
        chk("resp_after_ack", 32'(resp_valid), 32'd1);
      end else if (mem_req === 1'b1 && !rst) begin
        cnt++;
        if (cnt >= ram_delay) begin
          if (exp_mem.size() == 0) begin
            checks++;
            $display("FAIL unexpected_mem: got access addr 0x%0h required none", mem_addr);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_addr", 32'(mem_addr), 32'(m.addr));
            if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
          end
          mem_rdata = ram[mem_addr];
          if (mem_we) ram[mem_addr] = mem_wdata;
          mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Issue one request; lat > 0 also checks accept-to-response cycles.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                        input logic [WIDTH-1:0] er, input logic eh, input bit em, input int lat);
    int n;
    if (em) exp_mem.push_back('{we: we, addr: addr, wdata: wd});
    exp_resp.push_back('{rdata: er, hit: eh});
    wait_idle();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (resp_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (resp_valid !== 1'b1) begin
      checks++;
      $display("FAIL resp_timeout: got no resp_valid in %0d cycles required a response", n);
    end else if (lat > 0) begin
      chk("hit_latency", 32'(n), 32'(lat));
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required completion");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < int'(RAM_DEPTH); i++) ram[i] = '0;
    ram[8'h05] = 8'h11;
    ram[8'h15] = 8'h22;
    ram[8'h25] = 8'hAB;
    ram[8'h35] = 8'h44;
    ram[8'h45] = 8'h55;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("reset_resp_hit", 32'(resp_hit), 32'd0);

    // Cold miss then hit on the same address.
    do_req(1'b0, 8'h25, 8'h00, 8'hAB, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h25, 8'h00, 8'hAB, 1'b1, 1'b0, 2);

    // Fill set 1, touch 0x05, then 0x45 evicts the LRU line (0x15).
    rst_pulse();
    do_req(1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h15, 8'h00, 8'h22, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h25, 8'h00, 8'hAB, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h35, 8'h00, 8'h44, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h05, 8'h00, 8'h11, 1'b1, 1'b0, 2);
    do_req(1'b0, 8'h45, 8'h00, 8'h55, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h15, 8'h00, 8'h22, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h05, 8'h00, 8'h11, 1'b1, 1'b0, 2);

    // 0x25 was evicted by 0x15; bring it back (victim 0x35), then write-hit.
    do_req(1'b0, 8'h25, 8'h00, 8'hAB, 1'b0, 1'b1, 0);
    do_req(1'b1, 8'h25, 8'h3C, 8'h00, 1'b1, 1'b1, 0);
    do_req(1'b0, 8'h25, 8'h00, 8'h3C, 1'b1, 1'b0, 2);

    // Write miss does not allocate.
    do_req(1'b1, 8'h81, 8'h77, 8'h00, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h81, 8'h00, 8'h77, 1'b0, 1'b1, 0);

    // Reset during MEM_RD abandons the request and invalidates the cache.
    rst_pulse();
    ram_delay = 20;
    wait_idle();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h25;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("abort_mem_req_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req_low", 32'(mem_req), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    ram_delay = 3;
    do_req(1'b0, 8'h25, 8'h00, 8'h3C, 1'b0, 1'b1, 0);
    do_req(1'b0, 8'h25, 8'h00, 8'h3C, 1'b1, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
